// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory bus arbiter: access sizes, FSM states,
// requester tags and the IO-space address slice.
package mem_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] IO_HI_DEF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    REQ_IF,
    REQ_LD,
    REQ_ST
  } req_t;

  // Size code 11 is treated as a word access.
  function automatic logic [2:0] beat_count(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] io_slice(input logic [31:0] addr);
    return addr[17:16];
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// Byte/half/word zero- or sign-extender for assembled load data.
module mem_load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SIZE_B:  data = {{24{sign & raw[7]}}, raw[7:0]};
      SIZE_H:  data = {{16{sign & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO bus sequencer shared by fetch, speculative load and
// committed store; splits accesses into byte beats and assembles reads.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter logic [1:0] IO_HI  = IO_HI_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_data,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [1:0]        st_size,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_done,
  input  logic              uart_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_t            state;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q, mem_a_q;
  logic [DATA_W-1:0] wdata_q, buf_q, rd_word, ld_ext, if_data_q, ld_data_q;
  logic [1:0]        size_q, lane, next_lane;
  logic              signed_q;
  logic [2:0]        cnt, n_q, cnt_inc;
  logic [7:0]        mem_dout_q;
  logic              wr_q, if_done_q, ld_done_q, st_done_q, io_stall;

  assign cnt_inc   = cnt + 3'd1;
  assign lane      = cnt[1:0] - 2'd1;
  assign next_lane = cnt[1:0] + 2'd1;

  // An IO write beat is simply held back while the UART buffer is full;
  // the registered beat stays presented and retries every cycle.
  assign io_stall = (io_slice(mem_a_q) == IO_HI) && uart_full;

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = wr_q && rdy && !io_stall;
  assign if_done  = if_done_q && !clear;
  assign ld_done  = ld_done_q && !clear;
  assign st_done  = st_done_q;
  assign if_data  = if_data_q;
  assign ld_data  = ld_data_q;

  // Read cycle cnt (>=1) sees the byte addressed in the previous cycle.
  always_comb begin
    rd_word = buf_q;
    rd_word[{lane, 3'b000} +: 8] = mem_din;
  end

  mem_load_extend u_ext (
    .raw  (rd_word),
    .size (size_q),
    .sign (signed_q),
    .data (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= REQ_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      cnt        <= '0;
      n_q        <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      if_data_q  <= '0;
      ld_data_q  <= '0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          cnt   <= '0;
          buf_q <= '0;
          if (st_valid) begin
            state      <= ST_WRITE;
            req_q      <= REQ_ST;
            addr_q     <= st_addr;
            size_q     <= st_size;
            signed_q   <= 1'b0;
            wdata_q    <= st_data;
            n_q        <= beat_count(st_size);
            mem_a_q    <= st_addr;
            mem_dout_q <= st_data[7:0];
            wr_q       <= 1'b1;
          end else if (!clear && ld_valid) begin
            state    <= ST_READ;
            req_q    <= REQ_LD;
            addr_q   <= ld_addr;
            size_q   <= ld_size;
            signed_q <= ld_signed;
            n_q      <= beat_count(ld_size);
            mem_a_q  <= ld_addr;
          end else if (!clear && if_valid) begin
            state    <= ST_READ;
            req_q    <= REQ_IF;
            addr_q   <= if_addr;
            size_q   <= SIZE_W;
            signed_q <= 1'b0;
            n_q      <= 3'd4;
            mem_a_q  <= if_addr;
          end
        end

        ST_READ: begin
          if (clear) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mem_a_q <= '0;
          end else begin
            if (cnt != 3'd0) buf_q <= rd_word;
            if (cnt == n_q) begin
              state   <= ST_DONE;
              cnt     <= '0;
              mem_a_q <= '0;
              if (req_q == REQ_LD) begin
                ld_done_q <= 1'b1;
                ld_data_q <= ld_ext;
              end else begin
                if_done_q <= 1'b1;
                if_data_q <= rd_word;
              end
            end else begin
              cnt     <= cnt_inc;
              mem_a_q <= (cnt_inc < n_q) ? addr_q + ADDR_W'(cnt_inc) : '0;
            end
          end
        end

        ST_WRITE: begin
          if (!io_stall) begin
            if (cnt_inc == n_q) begin
              state      <= ST_DONE;
              cnt        <= '0;
              mem_a_q    <= '0;
              mem_dout_q <= '0;
              wr_q       <= 1'b0;
              st_done_q  <= 1'b1;
            end else begin
              cnt        <= cnt_inc;
              mem_a_q    <= addr_q + ADDR_W'(cnt_inc);
              mem_dout_q <= wdata_q[{next_lane, 3'b000} +: 8];
            end
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          if_done_q <= 1'b0;
          ld_done_q <= 1'b0;
          st_done_q <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected done
// pulses and write beats; monitors pop and compare on every DUT event.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 0, rst = 1, rdy = 1, clear = 0;
  logic        if_valid = 0, ld_valid = 0, st_valid = 0, ld_signed = 0, uart_full = 0;
  logic [31:0] if_addr = 0, ld_addr = 0, st_addr = 0, st_data = 0;
  logic [1:0]  ld_size = 0, st_size = 0;
  logic        if_done, ld_done, st_done, mem_wr;
  logic [31:0] if_data, ld_data, mem_a;
  logic [7:0]  mem_din = 0, mem_dout;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_signed(ld_signed),
    .ld_done(ld_done), .ld_data(ld_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
    .st_done(st_done), .uart_full(uart_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one-cycle read latency; frozen together with the core when rdy is low.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
      ram[12'h200] <= 8'h80;
      ram[12'h400] <= 8'h11; ram[12'h401] <= 8'h22; ram[12'h402] <= 8'h33; ram[12'h403] <= 8'h44;
      ram[12'h500] <= 8'h93; ram[12'h502] <= 8'h10;
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end
    if (rdy) mem_din <= ram[mem_a[11:0]];
  end

  typedef struct {int kind; logic [31:0] data; int at;} done_t;
  typedef struct {logic [31:0] addr; logic [7:0] data; int at;} wr_t;
  done_t sb[$];
  wr_t   wq[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_done(input int k, input logic [31:0] d, input int at);
    sb.push_back('{k, d, at});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d, input int at);
    wq.push_back('{a, d, at});
  endtask

  done_t de;
  wr_t   we;
  always @(negedge clk) begin
    if (mem_wr) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%02h expected no write", mem_a, mem_dout);
      end else begin
        we = wq.pop_front();
        chk("wr_addr", mem_a, we.addr);
        chk("wr_data", {24'h0, mem_dout}, {24'h0, we.data});
        chk("wr_cycle", cyc, we.at);
      end
    end
    if (if_done || ld_done || st_done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got if/ld/st=%0d%0d%0d expected none", if_done, ld_done, st_done);
      end else begin
        de = sb.pop_front();
        chk("done_kind", if_done ? 0 : (ld_done ? 1 : 2), de.kind);
        chk("done_data", if_done ? if_data : (ld_done ? ld_data : 32'h0), de.data);
        chk("done_cycle", cyc, de.at);
      end
    end
  end

  task automatic wait_pulse(input int which, input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((which == 0 && if_done) || (which == 1 && ld_done) || (which == 2 && st_done)) break;
    end
    checks++;
    if (i == 40) begin
      failures++;
      $display("FAIL %s: got no done pulse expected one within 40 cycles", name);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a);
    if_addr = a; if_valid = 1;
    wait_pulse(0, "fetch_timeout");
    if_valid = 0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    ld_addr = a; ld_size = sz; ld_signed = sg; ld_valid = 1;
    wait_pulse(1, "load_timeout");
    ld_valid = 0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    st_addr = a; st_size = sz; st_data = d; st_valid = 1;
    wait_pulse(2, "store_timeout");
    st_valid = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_a"}, mem_a, 32'h0);
    chk({tag, "_mem_dout"}, {24'h0, mem_dout}, 32'h0);
    chk({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
    chk({tag, "_if_done"}, {31'h0, if_done}, 32'h0);
    chk({tag, "_ld_done"}, {31'h0, ld_done}, 32'h0);
    chk({tag, "_st_done"}, {31'h0, st_done}, 32'h0);
    chk({tag, "_if_data"}, if_data, 32'h0);
    chk({tag, "_ld_data"}, ld_data, 32'h0);
    chk({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
  endtask

  int t;
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1; rst = 0;

    // Word fetch with address sequence
    @(posedge clk); #1; t = cyc;
    push_done(0, 32'h00000513, t + 6);
    fork
      do_fetch(32'h100);
      begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("fetch_mem_a", mem_a, 32'h100 + k);
          chk("fetch_mem_wr", {31'h0, mem_wr}, 32'h0);
        end
      end
    join

    // Signed and unsigned byte loads
    @(posedge clk); #1; t = cyc;
    push_done(1, 32'hFFFFFF80, t + 3);
    do_load(32'h200, SIZE_B, 1'b1);
    @(posedge clk); #1; t = cyc;
    push_done(1, 32'h00000080, t + 3);
    do_load(32'h200, SIZE_B, 1'b0);

    // Simultaneous requests: store, then load, then fetch
    @(posedge clk); #1; t = cyc;
    push_wr(32'h300, 8'hEF, t + 1);
    push_wr(32'h301, 8'hBE, t + 2);
    push_done(2, 32'h0, t + 3);
    push_done(1, 32'hFFFFBEEF, t + 8);
    push_done(0, 32'h00000513, t + 15);
    fork
      do_store(32'h300, SIZE_H, 32'h0000BEEF);
      do_load(32'h300, SIZE_H, 1'b1);
      do_fetch(32'h100);
    join

    // IO store held off by uart_full for 5 cycles
    uart_full = 1;
    @(posedge clk); #1; t = cyc;
    push_wr(32'h30000, 8'h41, t + 6);
    push_done(2, 32'h0, t + 7);
    fork
      do_store(32'h30000, SIZE_B, 32'h41);
      begin
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("uart_stall_mem_wr", {31'h0, mem_wr}, 32'h0);
        end
        @(posedge clk); #1; uart_full = 0;
      end
    join

    // clear during the 2nd beat of a word load; pending fetch follows
    @(posedge clk); #1; t = cyc;
    push_done(0, 32'h00100093, t + 9);
    ld_addr = 32'h400; ld_size = SIZE_W; ld_signed = 0; ld_valid = 1;
    if_addr = 32'h500; if_valid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; clear = 1; ld_valid = 0;
    @(posedge clk); #1; clear = 0;
    @(negedge clk);
    chk("clear_read_state", 32'(dut.state), 32'(ST_IDLE));
    chk("clear_read_mem_a", mem_a, 32'h0);
    wait_pulse(0, "fetch_after_clear_timeout");
    if_valid = 0;

    // clear during the DONE cycle of a load suppresses ld_done
    @(posedge clk); #1;
    ld_addr = 32'h200; ld_size = SIZE_B; ld_signed = 1; ld_valid = 1;
    repeat (3) @(posedge clk);
    #1; clear = 1; ld_valid = 0;
    @(negedge clk);
    chk("clear_done_state", 32'(dut.state), 32'(ST_DONE));
    @(posedge clk); #1; clear = 0;

    // clear during a word store does not abort it
    @(posedge clk); #1; t = cyc;
    push_wr(32'h600, 8'h0D, t + 1);
    push_wr(32'h601, 8'hF0, t + 2);
    push_wr(32'h602, 8'hFE, t + 3);
    push_wr(32'h603, 8'hCA, t + 4);
    push_done(2, 32'h0, t + 5);
    fork
      do_store(32'h600, SIZE_W, 32'hCAFEF00D);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1; clear = 1;
        @(posedge clk); #1; clear = 0;
      end
    join

    // rdy low for 3 cycles mid-read
    @(posedge clk); #1; t = cyc;
    push_done(1, 32'h44332211, t + 9);
    fork
      do_load(32'h400, SIZE_W, 1'b0);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1; rdy = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rdy_hold_mem_a", mem_a, 32'h401);
        @(posedge clk); #1; rdy = 1;
      end
    join

    // rdy low during a write beat suppresses mem_wr
    @(posedge clk); #1; t = cyc;
    push_wr(32'h710, 8'h5A, t + 3);
    push_done(2, 32'h0, t + 4);
    fork
      do_store(32'h710, SIZE_B, 32'h5A);
      begin
        @(posedge clk); #1; rdy = 0;
        @(posedge clk); #1;
        @(posedge clk); #1; rdy = 1;
      end
    join

    // rst mid-write abandons the store
    @(posedge clk); #1; t = cyc;
    push_wr(32'h700, 8'h04, t + 1);
    push_wr(32'h701, 8'h03, t + 2);
    st_addr = 32'h700; st_size = SIZE_W; st_data = 32'h01020304; st_valid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1; st_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1; rst = 0;

    @(posedge clk); #1; t = cyc;
    push_done(0, 32'h00000513, t + 6);
    do_fetch(32'h100);

    repeat (4) @(posedge clk);
    chk("sb_drained", sb.size(), 32'h0);
    chk("wq_drained", wq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM/IO bus between three requesters: instruction fetch (PC), speculative load (LSB) and committed store (ROB).
- Splits each 1/2/4-byte access into byte beats and assembles or extends read data.
- Stalls IO writes while the UART buffer is full, and honours flush and rdy.
- Sits between the PC/LSB/ROB units and the cpu-level mem_* pins.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, request data width.
- IO_HI, 2'b11, value of addr[17:16] that marks IO space.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; all state frozen when low
- clear  in  1  misprediction flush from ROB
- if_valid  in  1  fetch request (level, held until if_done)
- if_addr  in  32  fetch address (always 4 bytes)
- if_done  out  1  one-cycle pulse, if_data valid
- if_data  out  32  fetched instruction
- ld_valid  in  1  load request
- ld_addr  in  32  load address
- ld_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ld_signed  in  1  sign-extend result
- ld_done  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  extended load result
- st_valid  in  1  store request
- st_addr  in  32  store address
- st_size  in  2  encoding as ld_size
- st_data  in  32  store data, little-endian
- st_done  out  1  one-cycle pulse, store finished
- uart_full  in  1  io_buffer_full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, beat counter=0, all outputs 0. Reset mid-access abandons the access with no done pulse.
- rdy=0: no register changes. mem_wr is forced to 0 combinationally. Done pulses are held until rdy returns.

States:
- IDLE, READ, WRITE, DONE.

Arbitration (IDLE only):
- Priority store > load > fetch.
- Address, size, signed and data are latched at accept.
- If clear=1 in the same cycle, load and fetch are not accepted; a store may be.

READ (n = 1, 2 or 4 bytes):
- Accepted in cycle T.
- mem_a = addr+k, mem_wr=0, in cycles T+1..T+n.
- Byte k is captured from mem_din in cycle T+k+2 and placed at data[8k+7:8k].
- After the last byte is captured, the block enters DONE, and the done pulse and data are driven in cycle T+n+2.

WRITE:
- mem_a = addr+k, mem_dout = st_data[8k+7:8k], mem_wr=1, one beat per cycle.
- Completes in cycle T+n; st_done pulses in cycle T+n+1.
- If addr[17:16]==IO_HI and uart_full=1: the beat is not issued (mem_wr=0), the counter holds, and the beat retries each cycle until uart_full=0.

DONE:
- Exactly one cycle; returns to IDLE.
- No request is accepted in DONE, so the requester drops valid during this cycle.

Extension:
- Half and byte results are zero- or sign-extended per the latched signed bit.
- Fetch data is never extended.

clear:
- In READ, aborts the read: next state IDLE, no done pulse, counter reset.
- In DONE for a fetch or load, the done pulse is suppressed.
- WRITE is never aborted, because stores are committed.

Other rules:
- Addresses wrap modulo 2^32; no alignment check.
- mem_a, mem_dout and mem_wr are registered. They return to 0 in IDLE and DONE.

Decomposition:
- defines.v gets the size encodings (SIZE_B/H/W), state encodings, and the IO_HI value with its address-slice macro.
- One natural sub-module: mem_load_extend, a combinational byte/half/word sign-or-zero extender used for ld_data.
- Beat sequencing stays in mem_arbiter.

Test Plan:
1. Word fetch, if_addr=0x100, RAM bytes 13 05 00 00: mem_a=0x100..0x103 in T+1..T+4; if_done pulses in T+6 with if_data=0x00000513.
2. Signed byte load, ld_addr=0x200, byte 0x80, ld_signed=1: ld_data=0xFFFFFF80 with ld_done in T+3. Repeat with ld_signed=0: ld_data=0x00000080.
3. st_valid, ld_valid and if_valid all asserted in the same cycle: the store is served first (half at 0x300, data 0xBEEF → EF at 0x300, BE at 0x301, st_done at T+3), then the load, then the fetch.
4. Byte store to 0x30000 with uart_full=1 for 5 cycles: mem_wr stays 0 for those 5 cycles; the write is issued on the first cycle with uart_full=0, and st_done follows 1 cycle later.
5. clear asserted during the 2nd beat of a word load: no ld_done, state IDLE next cycle, a pending fetch is accepted afterwards. clear during a word store: all 4 beats complete and st_done pulses.
6. rdy held low for 3 cycles mid-read, then rst asserted mid-write: the read resumes with the same beat and correct data; after rst, all outputs are 0 and state is IDLE.
